mc_ctrl: RTL

Multi-cycle control FSM for the Microsystem MIPS core: sequences the shared ALU (alu_ctr 00 add, 01 sub, 10 or, 11 addi), PC, IR, register file and data memory through fetch/decode/execute/memory/writeback. It decodes the latched opcode/funct and drives all datapath write enables and mux selects for one instruction at a time. It also enforces the addi overflow rule: no register write on overflow.

---
 rtl/mips_ctrl_pkg.sv | 50 +++++
 rtl/instr_dec.sv | 35 +++
 rtl/mc_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared encodings for the multi-cycle MIPS control FSM
// Holds opcode/funct values, FSM state codes, ALU operation codes and the
// instruction-class enum used by instr_dec and mc_ctrl. No ports.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_OR   = 2'b10;
  localparam logic [1:0] ALU_ADDI = 2'b11;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    EXE_R   = 4'd2,
    EXE_I   = 4'd3,
    MEM_ADR = 4'd4,
    MEM_RD  = 4'd5,
    MEM_WR  = 4'd6,
    WB      = 4'd7,
    BRANCH  = 4'd8,
    JUMP    = 4'd9
  } state_t;

  // R_ADDU must stay at code 0: reset clears the class register to 0.
  typedef enum logic [3:0] {
    R_ADDU = 4'd0,
    R_SUBU = 4'd1,
    R_SLT  = 4'd2,
    I_ORI  = 4'd3,
    I_ADDI = 4'd4,
    LW     = 4'd5,
    SW     = 4'd6,
    BEQ    = 4'd7,
    J      = 4'd8,
    BAD    = 4'd9
  } instr_cls_t;

endpackage

// File: rtl/instr_dec.sv
// rtl/instr_dec.sv - combinational op/funct to instruction-class decoder
// Ports:
//   op    in  6  IR[31:26]
//   funct in  6  IR[5:0], only meaningful for R-type
//   cls   out    decoded instruction class, BAD for anything unsupported
module instr_dec
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output instr_cls_t cls
);

  always_comb begin
    cls = BAD;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: cls = R_ADDU;
          FN_SUBU: cls = R_SUBU;
          FN_SLT:  cls = R_SLT;
          default: cls = BAD;
        endcase
      end
      OP_ORI:  cls = I_ORI;
      OP_ADDI: cls = I_ADDI;
      OP_LW:   cls = LW;
      OP_SW:   cls = SW;
      OP_BEQ:  cls = BEQ;
      OP_J:    cls = J;
      default: cls = BAD;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle MIPS control FSM (fetch/decode/execute/mem/wb)
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   op, funct           latched instruction fields from IR
//   zero, overflow      ALU flags, sampled when leaving BRANCH / EXE_I
//   pc_wr, pc_src       PC write enable and next-PC select
//   ir_wr               IR write enable
//   alu_src_a/b, ext_op ALU operand selects and immediate extension mode
//   alu_ctr             ALU operation
//   reg_wr, reg_dst     register write enable and destination select
//   wd_src              register write-data select
//   dm_wr               data memory write enable
//   ovf_trap, illegal   one-cycle event pulses
//   state               current FSM state for debug
module mc_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  output logic       pc_wr,
  output logic [1:0] pc_src,
  output logic       ir_wr,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_op,
  output logic [1:0] alu_ctr,
  output logic       reg_wr,
  output logic       reg_dst,
  output logic [1:0] wd_src,
  output logic       dm_wr,
  output logic       ovf_trap,
  output logic       illegal,
  output logic [3:0] state
);

  state_t     state_q, state_nx;
  instr_cls_t cls_q, dec_cls;
  logic       ovf_q;

  instr_dec u_instr_dec (
    .op    (op),
    .funct (funct),
    .cls   (dec_cls)
  );

  assign state = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      cls_q   <= R_ADDU;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_nx;
      if (state_q == DECODE) begin
        cls_q <= dec_cls;
      end
      // Overflow only matters for addi; everything else clears or keeps it.
      if (state_q == FETCH) begin
        ovf_q <= 1'b0;
      end else if (state_q == EXE_I) begin
        ovf_q <= overflow & (cls_q == I_ADDI);
      end
    end
  end

  always_comb begin
    state_nx  = FETCH;
    pc_wr     = 1'b0;
    pc_src    = 2'b00;
    ir_wr     = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 2'b00;
    ext_op    = 1'b0;
    alu_ctr   = ALU_ADD;
    reg_wr    = 1'b0;
    reg_dst   = 1'b0;
    wd_src    = 2'b00;
    dm_wr     = 1'b0;
    ovf_trap  = 1'b0;
    illegal   = 1'b0;

    case (state_q)
      FETCH: begin
        pc_wr     = 1'b1;
        ir_wr     = 1'b1;
        alu_src_b = 2'b01;
        state_nx  = DECODE;
      end
      DECODE: begin
        // Branch target is precomputed here while the class is decoded.
        alu_src_b = 2'b11;
        ext_op    = 1'b1;
        case (dec_cls)
          R_ADDU, R_SUBU, R_SLT: state_nx = EXE_R;
          I_ORI, I_ADDI:         state_nx = EXE_I;
          LW, SW:                state_nx = MEM_ADR;
          BEQ:                   state_nx = BRANCH;
          J:                     state_nx = JUMP;
          default: begin
            illegal  = 1'b1;
            state_nx = FETCH;
          end
        endcase
      end
      EXE_R: begin
        alu_src_a = 1'b1;
        alu_ctr   = (cls_q == R_ADDU) ? ALU_ADD : ALU_SUB;
        state_nx  = WB;
      end
      EXE_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (cls_q == I_ORI) begin
          alu_ctr = ALU_OR;
        end else begin
          ext_op  = 1'b1;
          alu_ctr = ALU_ADDI;
        end
        state_nx = WB;
      end
      MEM_ADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        ext_op    = 1'b1;
        state_nx  = (cls_q == SW) ? MEM_WR : MEM_RD;
      end
      MEM_RD: state_nx = WB;
      MEM_WR: dm_wr = 1'b1;
      WB: begin
        reg_wr   = ~ovf_q;
        ovf_trap = ovf_q;
        reg_dst  = (cls_q == R_ADDU) || (cls_q == R_SUBU) || (cls_q == R_SLT);
        if (cls_q == R_SLT) begin
          wd_src = 2'b10;
        end else if (cls_q == LW) begin
          wd_src = 2'b01;
        end
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_ctr   = ALU_SUB;
        pc_src    = 2'b01;
        pc_wr     = zero;
      end
      JUMP: begin
        pc_src = 2'b10;
        pc_wr  = 1'b1;
      end
      default: state_nx = FETCH;
    endcase

    // Reset masks every enable and pulse even though the state reads FETCH.
    if (reset) begin
      pc_wr    = 1'b0;
      ir_wr    = 1'b0;
      reg_wr   = 1'b0;
      dm_wr    = 1'b0;
      ovf_trap = 1'b0;
      illegal  = 1'b0;
    end
  end

endmodule
